btn_action_beeper: RTL and testbench
====================================

Name: btn_action_beeper

Overview:
- Upstream conditioner for the action push-button. Feeds the buzzer tone stage.
- Synchronises and debounces the raw board button.
- Emits a one-cycle press strobe for game logic.
- Produces a fixed-length `btn_action` level that gates the DO tone in the buzzer stage. A bouncy or held button therefore yields exactly one clean beep per press.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; documentation only, not used in arithmetic.
- DEBOUNCE_CYCLES, 1_000_000, cycles the synchronised input must be stable before a level change is accepted (20 ms at 50 MHz).
- BEEP_CYCLES, 5_000_000, cycles `btn_action` stays high per accepted press (100 ms).
- BTN_ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_raw  input  1  raw, asynchronous, bouncing button pin
- btn_level  output  1  debounced button state, 1 = pressed
- btn_press  output  1  one-cycle strobe on each accepted press edge
- btn_action  output  1  beep-enable level to the buzzer tone stage

Behaviour:
- Reset (rst_n low, asynchronous):
  - all flops clear;
  - synchroniser flops load the "released" raw value (1 if BTN_ACTIVE_LOW, else 0);
  - outputs btn_level=0, btn_press=0, btn_action=0;
  - FSM returns to IDLE.
- Synchroniser:
  - 2-flop chain on btn_raw, then polarity-normalise to `pressed_s` (1 = pressed).
  - Latency from pin to `pressed_s` is 2 cycles.
- Debounce FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: `pressed_s`=1 → PRESS_WAIT, with the counter cleared.
  - PRESS_WAIT:
    - `pressed_s`=0 → IDLE (glitch rejected, no strobe);
    - counter reaches DEBOUNCE_CYCLES-1 with `pressed_s` still 1 → HELD. On that transition, btn_press pulses for exactly 1 cycle and btn_level goes 1.
  - HELD: `pressed_s`=0 → RELEASE_WAIT, with the counter cleared.
  - RELEASE_WAIT:
    - `pressed_s`=1 → HELD (bounce ignored);
    - counter reaches DEBOUNCE_CYCLES-1 with `pressed_s` still 0 → IDLE, and btn_level goes 0.
  - Counter is cleared on every state change and on any input reversal inside a WAIT state.
- Beep timer:
  - btn_press loads the beep counter and sets btn_action=1 in the following cycle.
  - btn_action stays 1 for exactly BEEP_CYCLES cycles, then drops to 0.
  - Holding the button does not extend or retrigger the beep.
  - A new btn_press while btn_action=1 reloads the counter (restart), so btn_action stays high continuously.
- Total latency from a clean pin press to btn_press = 2 + DEBOUNCE_CYCLES cycles.
- Counter widths use $clog2 of each parameter, minimum 1 bit. Counters must never wrap; each saturates at its terminal compare.
- Edge cases:
  - Release during the beep does not cut the beep short.
  - Reset asserted mid-beep forces btn_action=0 immediately.
  - DEBOUNCE_CYCLES=1 is legal: 1-cycle qualification.
  - btn_press and btn_action are registered outputs, glitch-free into the buzzer stage.

Decomposition:
- Shared package `buzzer_pkg` holds:
  - the FSM state encoding localparams (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3);
  - default timing constants at 50 MHz.
- One natural sub-module, `btn_debouncer`: synchroniser plus FSM plus debounce counter, producing btn_level and btn_press. The top instantiates it and adds the beep timer, so the debouncer is reusable for the other board buttons.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, BEEP_CYCLES=10, BTN_ACTIVE_LOW=1):
- Reset: hold rst_n=0, toggle btn_raw → btn_level, btn_press, btn_action all 0. Release reset with btn_raw=1 → outputs stay 0.
- Clean press: drive btn_raw 1→0 and hold → btn_press high for exactly 1 cycle, 6 cycles after the edge. btn_action high for exactly 10 cycles starting the next cycle. btn_level=1.
- Bounce: toggle btn_raw 0/1 every 2 cycles for 20 cycles, then hold 0 → exactly one btn_press, and no btn_action before the stable hold.
- Glitch: btn_raw low for 3 cycles, then back high → no btn_press, btn_action stays 0, FSM returns to IDLE.
- Retrigger: second clean press landing on beep cycle 7 → btn_action stays continuously high and ends 10 cycles after the second strobe. Two btn_press strobes total.
- Reset mid-beep: assert rst_n=0 on beep cycle 5 → btn_action=0 asynchronously (same delta). After release with button held, no spurious strobe until the button is released and pressed again.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared definitions for the action-button / buzzer path: debounce FSM
// state encoding, default timing at 50 MHz and a counter-width helper.
package buzzer_pkg;

    // Default timing for a 50 MHz board clock
    localparam int unsigned CLK_HZ_DEFAULT          = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;   // 20 ms
    localparam int unsigned BEEP_CYCLES_DEFAULT     = 5_000_000;   // 100 ms

    // Debounce FSM state encoding
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = ST_IDLE,
        PRESS_WAIT   = ST_PRESS_WAIT,
        HELD         = ST_HELD,
        RELEASE_WAIT = ST_RELEASE_WAIT
    } deb_state_e;

    // Width of a counter sized by $clog2 of its cycle count, never below 1 bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_action_beeper_if.sv
// Button-side signal bundle between the board pin / tone stage and the
// action-button conditioner. The conditioner sits on the slave side.
interface btn_action_beeper_if;

    logic btn_raw;      // raw, asynchronous, bouncing pin
    logic btn_level;    // debounced state, 1 = pressed
    logic btn_press;    // one-cycle strobe per accepted press
    logic btn_action;   // beep-enable level to the tone stage

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_action
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_action
    );

endinterface

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus four-state debounce FSM for one push-button.
// Produces a clean pressed level and a one-cycle strobe per accepted press.
// Kept free of any beep logic so the other board buttons can reuse it.
module btn_debouncer
    import buzzer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic btn_press_o
);

    localparam int unsigned CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam bit          SINGLE   = (DEBOUNCE_CYCLES <= 1);
    localparam logic        RELEASED = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

    // The cycle in which IDLE/HELD first sees the new level already counts as
    // the first stable cycle, so a WAIT state only has to cover the remaining
    // DEBOUNCE_CYCLES-1 cycles; its counter therefore terminates at D-2.
    localparam logic [CNT_W-1:0] DEB_TERM =
        (DEBOUNCE_CYCLES >= 2) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;

    logic       sync1_q;
    logic       sync2_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic       armed_d;
    logic       pressed_s;

    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;

    // Two-flop synchroniser; fill_q marks when the chain holds real pin samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

    // Normalise polarity so that 1 always means pressed
    assign pressed_s = sync2_q ^ RELEASED;

    // A button held through reset must be seen released once before it may
    // produce a press; the reset-loaded synchroniser value does not count.
    assign armed_d = armed_q | (fill_q[1] & ~pressed_s);

    // Debounce FSM next-state, counter and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed_s && armed_q) begin
                    cnt_d = '0;
                    if (SINGLE) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_TERM) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pressed_s) begin
                    cnt_d = '0;
                    if (SINGLE) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                    end else begin
                        state_d = RELEASE_WAIT;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_TERM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            armed_q <= armed_d;
        end
    end

    assign btn_level_o = level_q;
    assign btn_press_o = press_q;

endmodule

// File: rtl/btn_action_beeper.sv
// Action-button conditioner: debounces the board button and turns every
// accepted press into a fixed-length beep-enable level for the tone stage.
// A new press during a beep restarts the timer so the tone stays unbroken.
module btn_action_beeper
    import buzzer_pkg::*;
#(
    parameter int unsigned CLK_HZ          = CLK_HZ_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned BEEP_CYCLES     = BEEP_CYCLES_DEFAULT,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    btn_action_beeper_if.slave   bus
);

    localparam int unsigned BEEP_W = cnt_width(BEEP_CYCLES);
    localparam logic [BEEP_W-1:0] BEEP_TERM =
        (BEEP_CYCLES >= 1) ? BEEP_W'(BEEP_CYCLES - 1) : '0;

    // CLK_HZ only documents the clock the timing defaults were chosen for;
    // an unset value leaves an empty marker block in the hierarchy.
    if (CLK_HZ == 0) begin : g_clk_hz_unset
    end

    logic              press_w;
    logic              level_w;
    logic              action_q;
    logic              action_d;
    logic [BEEP_W-1:0] beep_cnt_q;
    logic [BEEP_W-1:0] beep_cnt_d;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_debouncer (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw_i   (bus.btn_raw),
        .btn_level_o (level_w),
        .btn_press_o (press_w)
    );

    // Beep timer: a press (re)loads the count, otherwise run to the terminal value
    always_comb begin
        action_d   = action_q;
        beep_cnt_d = beep_cnt_q;
        if (press_w) begin
            action_d   = 1'b1;
            beep_cnt_d = '0;
        end else if (action_q) begin
            if (beep_cnt_q == BEEP_TERM) begin
                action_d = 1'b0;
            end else begin
                beep_cnt_d = beep_cnt_q + 1'b1;
            end
        end
    end

    // Beep timer registers; reset kills a running beep at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            action_q   <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            action_q   <= action_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign bus.btn_level  = level_w;
    assign bus.btn_press  = press_w;
    assign bus.btn_action = action_q;

endmodule

// File: tb/tb_btn_action_beeper.sv
// Bench for btn_action_beeper with short timing (debounce 4, beep 10).
// The reference model tracks run lengths of the synchronised press level and
// a list of accepted press cycles; beep windows follow from that list.
module tb_btn_action_beeper;

    localparam int DEB  = 4;
    localparam int BEEP = 10;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    btn_action_beeper_if ifc ();

    btn_action_beeper #(
        .CLK_HZ          (50_000_000),
        .DEBOUNCE_CYCLES (DEB),
        .BEEP_CYCLES     (BEEP),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int   cyc;
    logic pinLog[$];
    int   pressLog[$];
    logic mLevel;
    logic mArmed;
    int   mRun;
    logic expLevel;
    logic expPress;
    logic expAction;

    // Expected outputs for the current cycle from the model history
    task automatic computeExpected();
        expPress  = 1'b0;
        expAction = 1'b0;
        foreach (pressLog[i]) begin
            if (pressLog[i] == cyc) expPress = 1'b1;
            if (cyc > pressLog[i] && cyc - pressLog[i] <= BEEP) expAction = 1'b1;
        end
        expLevel = mLevel;
    endtask

    // Drive the pin for the current cycle, advance the model, move to next cycle
    task automatic applyStimulus(input logic pin);
        logic ps;
        ifc.btn_raw = pin;
        pinLog.push_back(pin);
        ps = (cyc >= 2) ? (pinLog[cyc-2] == 1'b0) : 1'b0;
        if (mLevel || mArmed) begin
            if (ps != mLevel) mRun++;
            else mRun = 0;
            if (mRun == DEB) begin
                mLevel = ~mLevel;
                mRun = 0;
                if (mLevel) pressLog.push_back(cyc + 1);
            end
        end
        if (cyc >= 2 && !ps) mArmed = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        computeExpected();
    endtask

    // Release reset just after an edge with the pin at the given value
    task automatic startRun(input logic pin);
        @(posedge clk);
        #1;
        ifc.btn_raw = pin;
        rst_n = 1'b1;
        cyc = 0;
        pinLog.delete();
        pressLog.delete();
        mLevel = 1'b0;
        mArmed = 1'b0;
        mRun = 0;
        computeExpected();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ifc.btn_raw = 1'($urandom_range(0, 1));
            #2;
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== 3'b000) begin
                mismatched++;
                $display("[TB] FAIL reset_hold i=%0d got lvl/prs/act=%b expected=000",
                         i, {ifc.btn_level, ifc.btn_press, ifc.btn_action});
            end
            compared++;
        end
        startRun(1'b1);
        for (int i = 0; i < 10; i++) begin
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL reset_release cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
            applyStimulus(1'b1);
        end
    endtask

    task automatic test_clean_press();
        int edgeCyc;
        int pressAt;
        int pressCount;
        int actionCount;
        pressAt = -1;
        pressCount = 0;
        actionCount = 0;
        edgeCyc = cyc;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0);
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL clean_cycle cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
            if (ifc.btn_press === 1'b1) begin
                pressCount++;
                pressAt = cyc - edgeCyc;
            end
            if (ifc.btn_action === 1'b1) actionCount++;
        end
        if (pressCount !== 1 || pressAt !== 6) begin
            mismatched++;
            $display("[TB] FAIL clean_strobe got count=%0d offset=%0d expected count=1 offset=6",
                     pressCount, pressAt);
        end
        compared++;
        if (actionCount !== BEEP) begin
            mismatched++;
            $display("[TB] FAIL clean_beep_len got=%0d expected=%0d", actionCount, BEEP);
        end
        compared++;
        if (ifc.btn_level !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL clean_level got=%b expected=1", ifc.btn_level);
        end
        compared++;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1);
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL clean_release cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
        end
    endtask

    task automatic test_bounce();
        int pressCount;
        int earlyAction;
        int phase;
        pressCount = 0;
        earlyAction = 0;
        phase = int'($urandom_range(0, 1));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'(((i / 2) + phase) % 2));
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL bounce_cycle cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
            if (ifc.btn_press === 1'b1) pressCount++;
            if (ifc.btn_action === 1'b1) earlyAction++;
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0);
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL bounce_hold cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
            if (ifc.btn_press === 1'b1) pressCount++;
        end
        if (pressCount !== 1) begin
            mismatched++;
            $display("[TB] FAIL bounce_strobes got=%0d expected=1", pressCount);
        end
        compared++;
        if (earlyAction !== 0) begin
            mismatched++;
            $display("[TB] FAIL bounce_early_beep got=%0d expected=0", earlyAction);
        end
        compared++;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1);
    endtask

    task automatic test_glitch();
        int pressCount;
        int actionCount;
        int edgeCyc;
        int pressAt;
        pressCount = 0;
        actionCount = 0;
        pressAt = -1;
        for (int i = 0; i < 15; i++) begin
            applyStimulus((i < 3) ? 1'b0 : 1'b1);
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL glitch_cycle cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
            if (ifc.btn_press === 1'b1) pressCount++;
            if (ifc.btn_action === 1'b1 || ifc.btn_level === 1'b1) actionCount++;
        end
        if (pressCount !== 0 || actionCount !== 0) begin
            mismatched++;
            $display("[TB] FAIL glitch_reject got strobes=%0d active=%0d expected 0/0",
                     pressCount, actionCount);
        end
        compared++;
        // A fresh press right after the glitch shows full qualification from IDLE
        edgeCyc = cyc;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0);
            if (ifc.btn_press === 1'b1) pressAt = cyc - edgeCyc;
        end
        if (pressAt !== 6) begin
            mismatched++;
            $display("[TB] FAIL glitch_then_press got offset=%0d expected=6", pressAt);
        end
        compared++;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1);
    endtask

    task automatic test_back_to_back();
        int pressCyc[$];
        int firstAct;
        int lastAct;
        int actionCount;
        logic pin;
        firstAct = -1;
        lastAct = -1;
        actionCount = 0;
        // Shortest press/release/press the debouncer accepts: second strobe
        // lands 8 cycles after the first, i.e. on beep cycle index 7
        for (int i = 0; i < 36; i++) begin
            pin = (i < 4) ? 1'b0 : (i < 8) ? 1'b1 : (i < 32) ? 1'b0 : 1'b1;
            applyStimulus(pin);
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL retrig_cycle cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
            if (ifc.btn_press === 1'b1) pressCyc.push_back(cyc);
            if (ifc.btn_action === 1'b1) begin
                if (firstAct < 0) firstAct = cyc;
                lastAct = cyc;
                actionCount++;
            end
        end
        if (pressCyc.size() !== 2) begin
            mismatched++;
            $display("[TB] FAIL retrig_strobes got=%0d expected=2", pressCyc.size());
        end else begin
            if (pressCyc[1] - pressCyc[0] !== 8) begin
                mismatched++;
                $display("[TB] FAIL retrig_spacing got=%0d expected=8", pressCyc[1] - pressCyc[0]);
            end
            compared++;
            if (lastAct - pressCyc[1] !== BEEP) begin
                mismatched++;
                $display("[TB] FAIL retrig_end got=%0d expected=%0d", lastAct - pressCyc[1], BEEP);
            end
        end
        compared++;
        if (actionCount !== 18 || lastAct - firstAct + 1 !== actionCount) begin
            mismatched++;
            $display("[TB] FAIL retrig_continuous got len=%0d span=%0d expected 18/18",
                     actionCount, lastAct - firstAct + 1);
        end
        compared++;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1);
    endtask

    task automatic test_reset_mid_beep();
        int pressCount;
        int edgeCyc;
        int pressAt;
        pressCount = 0;
        pressAt = -1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0);
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL midbeep_lead cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL midbeep_async got=%b expected=000",
                     {ifc.btn_level, ifc.btn_press, ifc.btn_action});
        end
        compared++;
        @(posedge clk);
        @(posedge clk);
        startRun(1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0);
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL midbeep_held cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
            if (ifc.btn_press === 1'b1) pressCount++;
        end
        if (pressCount !== 0) begin
            mismatched++;
            $display("[TB] FAIL midbeep_spurious got=%0d expected=0", pressCount);
        end
        compared++;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1);
        edgeCyc = cyc;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0);
            if (ifc.btn_press === 1'b1) begin
                pressCount++;
                pressAt = cyc - edgeCyc;
            end
        end
        if (pressCount !== 1 || pressAt !== 6) begin
            mismatched++;
            $display("[TB] FAIL midbeep_repress got count=%0d offset=%0d expected 1/6",
                     pressCount, pressAt);
        end
        compared++;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1);
    endtask

    task automatic test_random();
        int total;
        int len;
        logic v;
        total = 0;
        while (total < 300) begin
            v = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
                applyStimulus(v);
                if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                    mismatched++;
                    $display("[TB] FAIL random_cycle cyc=%0d got=%b expected=%b", cyc,
                             {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
                end
                compared++;
            end
            total += len;
        end
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1);
            if ({ifc.btn_level, ifc.btn_press, ifc.btn_action} !== {expLevel, expPress, expAction}) begin
                mismatched++;
                $display("[TB] FAIL random_tail cyc=%0d got=%b expected=%b", cyc,
                         {ifc.btn_level, ifc.btn_press, ifc.btn_action}, {expLevel, expPress, expAction});
            end
            compared++;
        end
    endtask

    // Hard stop in case the sequence never completes
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        rst_n = 1'b0;
        ifc.btn_raw = 1'b1;
        cyc = 0;
        mLevel = 1'b0;
        mArmed = 1'b0;
        mRun = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_back_to_back();
        test_reset_mid_beep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
